// File: rtl/multi_filter_pkg.sv
// Shared types and default widths for the filter accumulate/normalise slice.
package multi_filter_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam int PROD_WIDTH_DEF = 63;
  localparam int TAPS_DEF       = 9;
  localparam int ACC_WIDTH_DEF  = 68;
  localparam int FRAC_BITS_DEF  = 16;
  localparam int OUT_WIDTH_DEF  = 8;

  function automatic int tap_cnt_w(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

  localparam int TAP_CNT_W_DEF = tap_cnt_w(TAPS_DEF);

endpackage

// File: rtl/multi_filter_acc_norm_if.sv
// Product-in / pixel-out handshake bundle for the accumulate/normalise block.
interface multi_filter_acc_norm_if #(
  parameter int PROD_WIDTH = 63,
  parameter int OUT_WIDTH  = 8
);
  logic                  prod_valid;
  logic [PROD_WIDTH-1:0] prod_data;
  logic                  prod_ready;
  logic                  pix_valid;
  logic [OUT_WIDTH-1:0]  pix_data;
  logic                  pix_sat;
  logic                  pix_ready;

  modport master (
    output prod_valid, prod_data, pix_ready,
    input  prod_ready, pix_valid, pix_data, pix_sat
  );

  modport slave (
    input  prod_valid, prod_data, pix_ready,
    output prod_ready, pix_valid, pix_data, pix_sat
  );
endinterface

// File: rtl/multi_filter_round_sat.sv
// Combinational round-half-up, right shift by FRAC_BITS and clamp to OUT_WIDTH.
module multi_filter_round_sat #(
  parameter int ACC_WIDTH = 68,
  parameter int FRAC_BITS = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0] sum,
  output logic [OUT_WIDTH-1:0] pix,
  output logic                 sat
);
  localparam logic [ACC_WIDTH:0] HALF    = (ACC_WIDTH+1)'(1) << (FRAC_BITS - 1);
  localparam logic [ACC_WIDTH:0] PIX_MAX = (ACC_WIDTH+1)'((1 << OUT_WIDTH) - 1);

  logic [ACC_WIDTH:0] rnd;
  logic [ACC_WIDTH:0] r;

  // one extra bit so the rounding add can never wrap
  assign rnd = {1'b0, sum} + HALF;
  assign r   = rnd >> FRAC_BITS;
  assign sat = (r > PIX_MAX);
  assign pix = sat ? PIX_MAX[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
endmodule

// File: rtl/multi_filter_acc_norm.sv
// Accumulates TAPS products per window, normalises and emits one pixel per window.
// Optional flush input acc_clr when MULTI_FILTER_ACC_NORM_CLR_EN is defined.
module multi_filter_acc_norm
  import multi_filter_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int TAPS       = TAPS_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
  input  logic acc_clr,
`endif
  multi_filter_acc_norm_if.slave bus
);
  localparam int CW = tap_cnt_w(TAPS);
  localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [CW-1:0]          tap_cnt, cnt_nxt;
  logic                   pix_valid, pv_nxt;
  logic [OUT_WIDTH-1:0]   pix_data, pd_nxt;
  logic                   pix_sat, ps_nxt;
  logic                   prod_rdy;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic [OUT_WIDTH-1:0]   rs_pix;
  logic                   rs_sat;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.prod_data};
  assign sum      = acc + prod_ext;

  multi_filter_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .sum (sum),
    .pix (rs_pix),
    .sat (rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      acc       <= '0;
      tap_cnt   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      tap_cnt   <= cnt_nxt;
      pix_valid <= pv_nxt;
      pix_data  <= pd_nxt;
      pix_sat   <= ps_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = tap_cnt;
    pv_nxt    = pix_valid;
    pd_nxt    = pix_data;
    ps_nxt    = pix_sat;
    prod_rdy  = 1'b0;
    if (ce) begin
      unique case (state)
        ACCUM: begin
          prod_rdy = 1'b1;
          if (bus.prod_valid) begin
            if (tap_cnt == LAST) begin
              pv_nxt    = 1'b1;
              pd_nxt    = rs_pix;
              ps_nxt    = rs_sat;
              state_nxt = EMIT;
            end else begin
              acc_nxt = sum;
              cnt_nxt = tap_cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          // a product arriving with the handshake opens the next window
          prod_rdy = bus.pix_ready;
          if (bus.pix_ready) begin
            pv_nxt    = 1'b0;
            state_nxt = ACCUM;
            if (bus.prod_valid) begin
              acc_nxt = prod_ext;
              cnt_nxt = CW'(1);
            end else begin
              acc_nxt = '0;
              cnt_nxt = '0;
            end
          end
        end
        default: ;
      endcase
    end
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
    if (acc_clr) begin
      prod_rdy  = 1'b0;
      state_nxt = ACCUM;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      pv_nxt    = 1'b0;
    end
`endif
  end

  assign bus.prod_ready = prod_rdy;
  assign bus.pix_valid  = pix_valid;
  assign bus.pix_data   = pix_data;
  assign bus.pix_sat    = pix_sat;
endmodule

// File: tb/tb_multi_filter_acc_norm.sv
// Directed bench for multi_filter_acc_norm: windows, rounding, saturation, stalls, reset.
module tb_multi_filter_acc_norm;
  logic clk;
  logic reset;
  logic ce;
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
  logic acc_clr;
`endif
  int n_vec;
  int n_err;

  multi_filter_acc_norm_if #(.PROD_WIDTH(63), .OUT_WIDTH(8)) bus ();

  multi_filter_acc_norm dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
    .acc_clr (acc_clr),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic feed(input logic [62:0] v);
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = v;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
  endtask

  // tap 0 = a, taps 1..8 = b, then stop driving; caller samples at that negedge
  task automatic run_window(input logic [62:0] a, input logic [62:0] b);
    feed(a);
    for (int i = 0; i < 8; i++) feed(b);
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ce = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod_data  = '0;
    bus.pix_ready  = 1'b1;
    #2;
    n_vec++; if (bus.pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_pix_valid got %0h exp 0", bus.pix_valid); end
    n_vec++; if (bus.pix_data !== 8'h00) begin n_err++; $display("FAIL reset_pix_data got %0h exp 0", bus.pix_data); end
    n_vec++; if (bus.pix_sat !== 1'b0) begin n_err++; $display("FAIL reset_pix_sat got %0h exp 0", bus.pix_sat); end
    n_vec++; if (bus.prod_ready !== 1'b1) begin n_err++; $display("FAIL reset_prod_ready got %0h exp 1", bus.prod_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_window(63'h10000, 63'h10000);
    n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0h exp 1", bus.pix_valid); end
    n_vec++; if (bus.pix_data !== 8'd9) begin n_err++; $display("FAIL basic_data got %0h exp 9", bus.pix_data); end
    n_vec++; if (bus.pix_sat !== 1'b0) begin n_err++; $display("FAIL basic_sat got %0h exp 0", bus.pix_sat); end
    @(negedge clk);
    n_vec++; if (bus.pix_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got %0h exp 0", bus.pix_valid); end
  endtask

  task automatic test_rounding();
    logic [62:0] sums [4];
    logic [7:0]  exps [4];
    sums[0] = 63'h8000;  exps[0] = 8'd1;
    sums[1] = 63'h7FFF;  exps[1] = 8'd0;
    sums[2] = 63'h17FFF; exps[2] = 8'd1;
    sums[3] = 63'h18000; exps[3] = 8'd2;
    for (int i = 0; i < 4; i++) begin
      run_window(sums[i], 63'h0);
      n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL round%0d_valid got %0h exp 1", i, bus.pix_valid); end
      n_vec++; if (bus.pix_data !== exps[i]) begin n_err++; $display("FAIL round%0d_data got %0h exp %0h", i, bus.pix_data, exps[i]); end
      n_vec++; if (bus.pix_sat !== 1'b0) begin n_err++; $display("FAIL round%0d_sat got %0h exp 0", i, bus.pix_sat); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    run_window(63'h1D0000, 63'h1D0000);
    n_vec++; if (bus.pix_data !== 8'hFF) begin n_err++; $display("FAIL sat_data got %0h exp ff", bus.pix_data); end
    n_vec++; if (bus.pix_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag got %0h exp 1", bus.pix_sat); end
    @(negedge clk);
    // near-limit but unclamped: 9 * 0xFF0000 / 2^16 would be 0x8F7, so use one big tap
    run_window(63'hFF0000, 63'h0);
    n_vec++; if (bus.pix_data !== 8'hFF) begin n_err++; $display("FAIL edge_data got %0h exp ff", bus.pix_data); end
    n_vec++; if (bus.pix_sat !== 1'b0) begin n_err++; $display("FAIL edge_sat got %0h exp 0", bus.pix_sat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 9; i++) feed(63'h10000);
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = 63'h20000;
    n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %0h exp 1", bus.pix_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (bus.pix_data !== 8'd9) begin n_err++; $display("FAIL bp_hold_data%0d got %0h exp 9", i, bus.pix_data); end
      n_vec++; if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready%0d got %0h exp 0", i, bus.prod_ready); end
      n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d got %0h exp 1", i, bus.pix_valid); end
    end
    @(negedge clk);
    bus.pix_ready = 1'b1;
    #1;
    n_vec++; if (bus.prod_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %0h exp 1", bus.prod_ready); end
    for (int i = 0; i < 8; i++) feed(63'h10000);
    idle();
    n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %0h exp 1", bus.pix_valid); end
    n_vec++; if (bus.pix_data !== 8'd10) begin n_err++; $display("FAIL b2b_data got %0h exp a", bus.pix_data); end
    @(negedge clk);
  endtask

  task automatic test_ce_stall();
    for (int i = 0; i < 4; i++) feed(63'h10000);
    @(negedge clk);
    ce = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = 63'h30000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL ce_ready%0d got %0h exp 0", i, bus.prod_ready); end
      if (i < 2) @(negedge clk);
    end
    @(negedge clk);
    ce = 1'b1;
    bus.prod_data = 63'h10000;
    for (int i = 0; i < 4; i++) feed(63'h10000);
    // stall the emit as well: pixel must survive ce=0 with pix_ready=1
    @(negedge clk);
    ce = 1'b0;
    bus.prod_valid = 1'b0;
    n_vec++; if (bus.pix_data !== 8'd9) begin n_err++; $display("FAIL ce_data got %0h exp 9", bus.pix_data); end
    repeat (2) @(negedge clk);
    n_vec++; if (bus.pix_valid !== 1'b1) begin n_err++; $display("FAIL ce_emit_hold got %0h exp 1", bus.pix_valid); end
    ce = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.pix_valid !== 1'b0) begin n_err++; $display("FAIL ce_emit_done got %0h exp 0", bus.pix_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) feed(63'h50000);
    @(negedge clk);
    bus.prod_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++; if (bus.pix_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data got %0h exp 0", bus.pix_data); end
    n_vec++; if (bus.pix_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %0h exp 0", bus.pix_valid); end
    @(negedge clk);
    reset = 1'b1;
    run_window(63'h10000, 63'h10000);
    n_vec++; if (bus.pix_data !== 8'd9) begin n_err++; $display("FAIL rst_fresh_data got %0h exp 9", bus.pix_data); end
    @(negedge clk);
  endtask

`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
  task automatic test_acc_clr();
    for (int i = 0; i < 5; i++) feed(63'h50000);
    @(negedge clk);
    acc_clr = 1'b1;
    #1;
    n_vec++; if (bus.prod_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready got %0h exp 0", bus.prod_ready); end
    @(negedge clk);
    acc_clr = 1'b0;
    bus.prod_valid = 1'b0;
    run_window(63'h10000, 63'h10000);
    n_vec++; if (bus.pix_data !== 8'd9) begin n_err++; $display("FAIL clr_data got %0h exp 9", bus.pix_data); end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
    acc_clr = 1'b0;
`endif
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
`ifdef MULTI_FILTER_ACC_NORM_CLR_EN
    test_acc_clr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
